// File: rtl/pipe_pkg.sv
// Shared types and constants for the EXE->MEM skid stage.
// Default widths, control bundle bit map and the stage occupancy enum.
package pipe_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CTRL_W  = 15;
  localparam int DEF_RADDR_W = 5;

  // Bit positions inside the packed control bundle; 11..14 are spare.
  localparam int CTRL_MEM_TO_REG = 0;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_RTYPE      = 4;
  localparam int CTRL_LW         = 5;
  localparam int CTRL_SW         = 6;
  localparam int CTRL_J          = 7;
  localparam int CTRL_BEQ        = 8;
  localparam int CTRL_BNE        = 9;
  localparam int CTRL_NOP        = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  function automatic logic ctrl_is_mem_op(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable; clears on synchronous reset only.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/exe_mem_skid_stage.sv
// EXE->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module exe_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_alu_res,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [RADDR_W-1:0] in_reg_dest,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_addr,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [RADDR_W-1:0] out_reg_dest
`ifdef STAGE_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  stage_state_e state_q, state_d;
  logic load_m_in, load_m_s, load_s;
  logic accept, deliver;

  logic [CTRL_W-1:0]  m_ctrl, s_ctrl;
  logic [DATA_W-1:0]  m_addr, s_addr, m_wdata, s_wdata;
  logic [RADDR_W-1:0] m_dest, s_dest;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d   = ONE;
        load_m_in = 1'b1;
      end
      ONE: begin
        if (accept && deliver) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          state_d = TWO;
          load_s  = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: if (deliver) begin
        state_d  = ONE;
        load_m_s = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any same-cycle accept; payload registers keep their contents.
    if (flush) begin
      state_d   = EMPTY;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
      m_ctrl   <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_dest   <= '0;
      s_ctrl   <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_dest   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
      if (load_m_in) begin
        m_ctrl  <= in_ctrl;
        m_addr  <= in_alu_res;
        m_wdata <= in_wdata;
        m_dest  <= in_reg_dest;
      end else if (load_m_s) begin
        m_ctrl  <= s_ctrl;
        m_addr  <= s_addr;
        m_wdata <= s_wdata;
        m_dest  <= s_dest;
      end
      if (load_s) begin
        s_ctrl  <= in_ctrl;
        s_addr  <= in_alu_res;
        s_wdata <= in_wdata;
        s_dest  <= in_reg_dest;
      end
    end
  end

  assign out_ctrl     = out_valid ? m_ctrl : '0;
  assign out_addr     = m_addr;
  assign out_wdata    = m_wdata;
  assign out_reg_dest = m_dest;

`ifdef STAGE_PERF_EN
  pipe_perf_cnt #(.W(32)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.W(32)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .en  (~out_valid),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_exe_mem_skid_stage.sv
// Directed and scoreboard-driven checks of the EXE->MEM skid stage.
module tb_exe_mem_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [14:0] in_ctrl, out_ctrl;
  logic [31:0] in_alu_res, in_wdata, out_addr, out_wdata;
  logic [4:0]  in_reg_dest, out_reg_dest;
`ifdef STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_mem_skid_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_alu_res   (in_alu_res),
    .in_wdata     (in_wdata),
    .in_reg_dest  (in_reg_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_reg_dest (out_reg_dest)
`ifdef STAGE_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    in_valid    = v;
    in_alu_res  = a;
    in_wdata    = a ^ 32'hA5A5_0000;
    in_ctrl     = a[14:0] | 15'h0400;
    in_reg_dest = a[4:0] + 5'd3;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    step(); step();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 15'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_addr !== 32'h0 || out_reg_dest !== 5'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", out_addr, out_reg_dest);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i);
      step();
      total++; if (out_valid !== 1'b1 || out_addr !== 32'h10 + i) begin
        bad++; $display("FAIL stream_addr[%0d] got=%b/%h exp=1/%h", i, out_valid, out_addr, 32'h10 + i);
      end
      total++; if (out_ctrl !== ((15'h10 + 15'(i)) | 15'h0400) || out_wdata !== ((32'h10 + i) ^ 32'hA5A5_0000)) begin
        bad++; $display("FAIL stream_payload[%0d] got=%h/%h", i, out_ctrl, out_wdata);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    drive(1'b0, 32'h0);
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 15'h0) begin
      bad++; $display("FAIL stream_drain got=%b/%h exp=0/0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h20); step();
    drive(1'b1, 32'h21); step();
    drive(1'b0, 32'h0);
    total++; if (in_ready !== 1'b0 || out_addr !== 32'h20 || out_valid !== 1'b1) begin
      bad++; $display("FAIL stall_two got=rdy%b/%h exp=rdy0/20", in_ready, out_addr);
    end
    out_ready = 1'b1;
    step();
    total++; if (out_addr !== 32'h21 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_second got=%h/rdy%b exp=21/rdy1", out_addr, in_ready);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h40); step();
    drive(1'b1, 32'h41); step();
    drive(1'b1, 32'h30); flush = 1'b1;
    step();
    flush = 1'b0; drive(1'b0, 32'h0);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 15'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_two got=v%b/%h/rdy%b exp=v0/0/rdy1", out_valid, out_ctrl, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0 || out_addr !== 32'h40) begin
        bad++; $display("FAIL flush_after[%0d] got=v%b/%h exp=v0/40", i, out_valid, out_addr);
      end
    end
  endtask

  task automatic test_rst_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h50); step();
    drive(1'b1, 32'h51); rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 15'h0 || out_addr !== 32'h0 ||
                 out_wdata !== 32'h0 || out_reg_dest !== 5'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_flush got=v%b c%h a%h w%h d%h r%b", out_valid, out_ctrl,
                      out_addr, out_wdata, out_reg_dest, in_ready);
    end
  endtask

  task automatic test_random();
    logic [83:0] q[$];
    logic [83:0] obs, exp;
    logic [31:0] seq = 32'h100;
    logic acc, del;
    int errs = 0;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 9) < 7, seq);
      out_ready = $urandom_range(0, 9) < 6;
      flush = ($urandom_range(0, 49) == 0);
      total++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_flags c=%0d got=v%b/r%b occ=%0d", c, out_valid, in_ready, q.size());
      end
      acc = in_valid & in_ready;
      del = out_valid & out_ready;
      if (del && q.size() != 0) begin
        exp = q.pop_front();
        obs = {out_ctrl, out_addr, out_wdata, out_reg_dest};
        total++; if (obs !== exp) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rand_data c=%0d got=%h exp=%h", c, obs, exp);
        end
      end
      if (flush) q.delete();
      else if (acc) begin
        q.push_back({in_ctrl, in_alu_res, in_wdata, in_reg_dest});
        seq++;
      end
      step();
    end
    flush = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b1;
    step(); step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
  endtask

`ifdef STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0);
    step();
    rst = 1'b0;
    step(); step();
    drive(1'b1, 32'h60); step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt); end
    total++; if (bubble_cnt !== 32'd3) begin bad++; $display("FAIL perf_bubble got=%0d exp=3", bubble_cnt); end
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (stall_cnt !== 32'd6) begin bad++; $display("FAIL perf_no_flush_clr got=%0d exp=6", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_rst_flush();
    test_random();
`ifdef STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid_stage.md
Name: exe_mem_skid_stage

Overview:
- Parametrised successor to the fixed EXE->MEM pipeline register.
- Carries the control bundle, ALU result, store data and destination register from EXE to MEM.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble (NOP) forcing.
- Lets MEM stall without a combinational ready path back into EXE/hazard logic.

Parameters:
- DATA_W, 32, width of ALU result/address and store data.
- CTRL_W, 15, width of the packed control bundle; bit map lives in the package.
- RADDR_W, 5, width of the destination register index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous kill of all held entries (branch/jump redirect).
- in_valid  input  1  EXE presents a valid instruction.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_ctrl  input  CTRL_W  packed control: mem_to_reg, reg_write, mem_write, mem_read, Rtype, lw, sw, j, beq, bne, nop, ...
- in_alu_res  input  DATA_W  ALU result.
- in_wdata  input  DATA_W  store data.
- in_reg_dest  input  RADDR_W  destination register.
- out_valid  output  1  MEM-side entry valid.
- out_ready  input  1  MEM accepts the entry.
- out_ctrl  output  CTRL_W  control; forced to 0 when out_valid=0.
- out_addr  output  DATA_W  registered ALU result.
- out_wdata  output  DATA_W  registered store data.
- out_reg_dest  output  RADDR_W  registered destination.

Behaviour:
- Storage: main entry M drives the outputs; skid entry S. Each entry has a valid bit.
- State machine (package enum):
  - EMPTY: no valid entries.
  - ONE: M valid.
  - TWO: M and S valid.
- Handshake: accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE; M <= input.
  - ONE, accept and deliver -> ONE; M <= input.
  - ONE, accept and no deliver -> TWO; S <= input.
  - ONE, deliver only -> EMPTY.
  - TWO, deliver -> ONE; M <= S. in_ready is 0 in TWO, so no accept.
  - Otherwise hold.
- in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- Latency: 1 cycle input-to-output when unstalled. Throughput 1/cycle with out_ready held high.
- Data ordering is strictly FIFO. No entry is duplicated or dropped except by flush/rst.
- Bubble rule: out_ctrl = 0 whenever out_valid = 0. Data outputs hold their last value.
- flush: next state EMPTY and both valid bits cleared.
  - flush takes priority over a same-cycle accept; that input is dropped.
  - A same-cycle deliver still counts for MEM.
  - Data registers are not cleared.
- rst: highest priority over flush and handshakes. Next state EMPTY, all data and ctrl registers 0, in_ready = 1 after reset.
- rst asserted mid-stall (TWO): both entries discarded.
- Width handling: payloads are copied verbatim. No arithmetic, no sign extension.

Optional Feature:
- Macro STAGE_PERF_EN.
- When defined, adds output ports stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid.
  - Both saturate at 32'hFFFF_FFFF and clear on rst only, not on flush.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - stage_state_e {EMPTY, ONE, TWO}.
  - Default width localparams.
  - Control bit-index constants CTRL_MEM_TO_REG .. CTRL_NOP.
  - Function ctrl_is_mem_op().
- Sub-module pipe_perf_cnt: parametrised saturating counter with enable, instantiated twice under STAGE_PERF_EN. Nothing else is split out.

Test Plan:
- Reset, then stream: rst=1 for 2 cycles, then 4 entries A=0x10..D=0x13 with out_ready=1 -> outputs appear one cycle later in order 0x10..0x13; in_ready stays 1; out_ctrl=0 before the first entry.
- Stall fill: out_ready=0, push 0x20 then 0x21 -> state TWO, in_ready=0, out_addr=0x20. Raise out_ready -> 0x20, then 0x21 delivered on consecutive cycles; in_ready=1 one cycle after the first deliver.
- Flush in TWO with in_valid=1 (0x30) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x30 is never output.
- rst and flush asserted together, plus in_valid, during ONE -> all outputs 0 next cycle, state EMPTY.
- Random valid/ready traffic for 10k cycles -> scoreboard shows exact in-order delivery, no loss or duplication outside flush, and in_ready never 1 in TWO.
- STAGE_PERF_EN: 5 stall cycles plus 3 idle cycles -> stall_cnt=5, bubble_cnt=3. Counter preloaded to 0xFFFF_FFFE plus 3 stall cycles -> stall_cnt=0xFFFF_FFFF.
